// File: rtl/vga_frame_reader.sv
// vga_frame_reader
//   Generates 640x480@60 VGA raster timing from the 25 MHz pixel clock and reads a
//   320x240 RGB565 frame buffer with 2x2 pixel replication. The raster flags travel
//   down a delay line that matches the frame buffer read latency, so that pixel data,
//   address, active flag, syncs and frame_start all leave the block aligned.
// Ports:
//   clk, rst_n      pixel clock, asynchronous active-low reset
//   enable          run timing; low holds the raster at (0,0) with outputs idle
//   fb_rd_addr      frame buffer read address {y[7:0], x[8:0]} for the current raster
//   fb_rd_data      frame buffer read data, valid RAM_LATENCY clocks after the address
//   pixel_data      RGB565 pixel aligned with pixel_addr, zero outside the active area
//   pixel_addr      {y[7:0], x[8:0]} of the pixel on pixel_data
//   active_area     visible pixel flag
//   hsync, vsync    active-low syncs
//   frame_start     one-cycle pulse on output raster (0,0)
module vga_frame_reader #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned RAM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic [16:0] fb_rd_addr,
  input  logic [15:0] fb_rd_data,
  output logic [15:0] pixel_data,
  output logic [16:0] pixel_addr,
  output logic        active_area,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Counter width is fixed by the {v[8:1], h[9:1]} address packing.
  localparam int unsigned CW       = 10;
  localparam int unsigned AW       = 17;
  localparam int unsigned HS_FIRST = H_ACTIVE + H_FP;
  localparam int unsigned HS_LAST  = HS_FIRST + H_SYNC - 1;
  localparam int unsigned VS_FIRST = V_ACTIVE + V_FP;
  localparam int unsigned VS_LAST  = VS_FIRST + V_SYNC - 1;

  typedef struct packed {
    logic          act;
    logic          hs_n;
    logic          vs_n;
    logic          fs;
    logic [AW-1:0] addr;
  } raster_t;

  localparam raster_t RASTER_IDLE = '{act: 1'b0, hs_n: 1'b1, vs_n: 1'b1, fs: 1'b0,
                                      addr: AW'(0)};

  logic [CW-1:0] h_cnt, v_cnt;
  logic [CW-1:0] h_nxt, v_nxt;
  raster_t       ras_cur;
  raster_t       pipe [RAM_LATENCY];

  // Visible pixel test for a counter state.
  function automatic logic is_active(input logic [CW-1:0] h, input logic [CW-1:0] v);
    return (h < CW'(H_ACTIVE)) && (v < CW'(V_ACTIVE));
  endfunction

  // Replicated source address: halving h and v reads each pixel for a 2x2 block.
  function automatic logic [AW-1:0] addr_of(input logic [CW-1:0] h, input logic [CW-1:0] v);
    return is_active(h, v) ? {v[8:1], h[9:1]} : AW'(0);
  endfunction

  // Full raster stage for a counter state.
  function automatic raster_t raster_of(input logic [CW-1:0] h, input logic [CW-1:0] v);
    raster_t r;
    r.act  = is_active(h, v);
    r.hs_n = !((h >= CW'(HS_FIRST)) && (h <= CW'(HS_LAST)));
    r.vs_n = !((v >= CW'(VS_FIRST)) && (v <= CW'(VS_LAST)));
    r.fs   = (h == CW'(0)) && (v == CW'(0));
    r.addr = addr_of(h, v);
    return r;
  endfunction

  // Next counter state; disabled timing parks the raster at the origin.
  always_comb begin
    h_nxt   = '0;
    v_nxt   = '0;
    ras_cur = RASTER_IDLE;
    if (enable) begin
      ras_cur = raster_of(h_cnt, v_cnt);
      if (h_cnt == CW'(H_TOTAL - 1)) begin
        h_nxt = '0;
        v_nxt = (v_cnt == CW'(V_TOTAL - 1)) ? CW'(0) : v_cnt + CW'(1);
      end else begin
        h_nxt = h_cnt + CW'(1);
        v_nxt = v_cnt;
      end
    end
  end

  // Counters, read address (from next state so it tracks the counters with no
  // combinational path) and the latency-matching delay line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt      <= '0;
      v_cnt      <= '0;
      fb_rd_addr <= '0;
      for (int i = 0; i < RAM_LATENCY; i++) pipe[i] <= RASTER_IDLE;
    end else begin
      h_cnt      <= h_nxt;
      v_cnt      <= v_nxt;
      fb_rd_addr <= addr_of(h_nxt, v_nxt);
      if (!enable) begin
        for (int i = 0; i < RAM_LATENCY; i++) pipe[i] <= RASTER_IDLE;
      end else begin
        pipe[0] <= ras_cur;
        for (int i = 1; i < RAM_LATENCY; i++) pipe[i] <= pipe[i-1];
      end
    end
  end

  assign pixel_addr  = pipe[RAM_LATENCY-1].addr;
  assign active_area = pipe[RAM_LATENCY-1].act;
  assign hsync       = pipe[RAM_LATENCY-1].hs_n;
  assign vsync       = pipe[RAM_LATENCY-1].vs_n;
  assign frame_start = pipe[RAM_LATENCY-1].fs;
  // Read data arrives in the same cycle as its delayed address; mask it outside video.
  assign pixel_data  = pipe[RAM_LATENCY-1].act ? fb_rd_data : 16'h0000;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Testbench for vga_frame_reader: one full-size instance (latency 2) and three
// shrunken-raster instances (latency 1, 2, 4) share clock, reset and enable. A
// position-count model predicts every output each cycle; directed checks pin the
// model and the timing landmarks.
module tb_vga_frame_reader;

  localparam int S_HA = 20, S_HFP = 3, S_HS = 5, S_HBP = 4;
  localparam int S_VA = 10, S_VFP = 2, S_VS = 2, S_VBP = 3;
  localparam int S_FRAME = 32 * 17;

  typedef struct packed {
    int ha, hfp, hs, hbp, va, vfp, vs, vbp, lat;
  } cfg_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b1;

  logic [16:0] fb  [4];
  logic [15:0] rd  [4];
  logic [15:0] pd  [4];
  logic [16:0] pa  [4];
  logic        act [4];
  logic        hs  [4];
  logic        vs  [4];
  logic        fs  [4];

  logic [15:0] mem [0:131071];
  logic [16:0] rp  [4][4];

  int k = 0;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vga_frame_reader #(.RAM_LATENCY(2)) u_full (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fb_rd_addr(fb[0]), .fb_rd_data(rd[0]),
    .pixel_data(pd[0]), .pixel_addr(pa[0]), .active_area(act[0]), .hsync(hs[0]),
    .vsync(vs[0]), .frame_start(fs[0]));

  vga_frame_reader #(.H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
                     .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
                     .RAM_LATENCY(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fb_rd_addr(fb[1]), .fb_rd_data(rd[1]),
    .pixel_data(pd[1]), .pixel_addr(pa[1]), .active_area(act[1]), .hsync(hs[1]),
    .vsync(vs[1]), .frame_start(fs[1]));

  vga_frame_reader #(.H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
                     .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
                     .RAM_LATENCY(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fb_rd_addr(fb[2]), .fb_rd_data(rd[2]),
    .pixel_data(pd[2]), .pixel_addr(pa[2]), .active_area(act[2]), .hsync(hs[2]),
    .vsync(vs[2]), .frame_start(fs[2]));

  vga_frame_reader #(.H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
                     .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
                     .RAM_LATENCY(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fb_rd_addr(fb[3]), .fb_rd_data(rd[3]),
    .pixel_data(pd[3]), .pixel_addr(pa[3]), .active_area(act[3]), .hsync(hs[3]),
    .vsync(vs[3]), .frame_start(fs[3]));

  // Frame buffer models: random contents, data valid RAM_LATENCY clocks after address.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      for (int s = 3; s > 0; s--) rp[i][s] <= rp[i][s-1];
      rp[i][0] <= fb[i];
    end
  end
  assign rd[0] = mem[rp[0][1]];
  assign rd[1] = mem[rp[1][0]];
  assign rd[2] = mem[rp[2][1]];
  assign rd[3] = mem[rp[3][3]];

  // Raster position: enabled clocks since the last restart from the origin.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      k <= 0;
    else if (enable) k <= k + 1;
    else             k <= 0;
  end

  function automatic cfg_t cfg_of(input int i);
    cfg_t c;
    if (i == 0) c = '{640, 16, 96, 48, 480, 10, 2, 33, 2};
    else        c = '{S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, (i == 3) ? 4 : i};
    return c;
  endfunction

  // Read address the raster is on after kk enabled clocks.
  function automatic logic [16:0] addr_at(input int kk, input cfg_t c);
    int ht, vt, h, v;
    ht = c.ha + c.hfp + c.hs + c.hbp;
    vt = c.va + c.vfp + c.vs + c.vbp;
    h  = kk % ht;
    v  = (kk / ht) % vt;
    if (h < c.ha && v < c.va) return 17'((v / 2) * 512 + h / 2);
    return 17'h0;
  endfunction

  // Expected {pixel_addr, pixel_data, active_area, hsync, vsync, frame_start}.
  function automatic logic [36:0] out_at(input int kk, input cfg_t c);
    int ht, vt, pos, h, v;
    logic a, hsn, vsn, f;
    logic [16:0] ad;
    logic [15:0] d;
    if (kk < c.lat) return {17'h0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0};
    ht  = c.ha + c.hfp + c.hs + c.hbp;
    vt  = c.va + c.vfp + c.vs + c.vbp;
    pos = kk - c.lat;
    h   = pos % ht;
    v   = (pos / ht) % vt;
    a   = (h < c.ha) && (v < c.va);
    ad  = addr_at(pos, c);
    d   = a ? mem[ad] : 16'h0;
    hsn = !(h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hs);
    vsn = !(v >= c.va + c.vfp && v < c.va + c.vfp + c.vs);
    f   = (pos % (ht * vt)) == 0;
    return {ad, d, a, hsn, vsn, f};
  endfunction

  function automatic logic [36:0] got_vec(input int i);
    return {pa[i], pd[i], act[i], hs[i], vs[i], fs[i]};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_idle(input string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s idle out[%0d]", tag, i), 64'(got_vec(i)),
            64'({17'h0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0}));
      check($sformatf("%s idle fb[%0d]", tag, i), 64'(fb[i]), 64'h0);
    end
  endtask

  // Every-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fb_rd_addr[%0d] k=%0d", i, k), 64'(fb[i]), 64'(addr_at(k, cfg_of(i))));
      check($sformatf("outputs[%0d] k=%0d", i, k), 64'(got_vec(i)), 64'(out_at(k, cfg_of(i))));
    end
  end

  int lit_k  [13] = '{1, 2, 3, 4, 639, 640, 641, 799, 802, 1600, 1601, 1602, 1638};
  int lit_a  [13] = '{0, 1, 1, 2, 'h13F, 0, 0, 0, 1, 'h200, 'h200, 'h201, 'h213};

  initial begin
    int full_hs, full_act, full_fs, s_hs, s_vs, s_act, s_fs, rise_k, gap, n, len;
    logic prev_vs;
    for (int a = 0; a < 131072; a++) mem[a] = 16'($urandom);

    // Model pins against hand-computed landmarks.
    check("model line479 end", 64'(addr_at(479 * 800 + 639, cfg_of(0))), 64'h1DF3F);
    check("model line2 start", 64'(addr_at(1600, cfg_of(0))), 64'h200);
    check("model hsync first low", 64'(out_at(2 + 656, cfg_of(0))), 64'({17'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0}));

    rst_n  = 1'b0;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_idle("reset");
    rst_n = 1'b1;

    // Undisturbed run: address landmarks, line stats on full size, frame stats on small.
    full_hs = 0; full_act = 0; full_fs = 0;
    s_hs = 0; s_vs = 0; s_act = 0; s_fs = 0; rise_k = -1; gap = -1; prev_vs = 1'b1;
    for (int c = 0; c < 1900; c++) begin
      step();
      for (int j = 0; j < 13; j++)
        if (k == lit_k[j]) check($sformatf("line addr k=%0d", k), 64'(fb[0]), 64'(lit_a[j]));
      if (k >= 2 && k < 2 + 1600) begin
        if (!hs[0]) full_hs++;
        if (act[0]) full_act++;
      end
      if (fs[0]) full_fs++;
      if (k >= 2 && k < 2 + 2 * S_FRAME) begin
        if (!hs[2]) s_hs++;
        if (!vs[2]) s_vs++;
        if (act[2]) s_act++;
        if (fs[2]) s_fs++;
        if (vs[2] && !prev_vs && rise_k < 0) rise_k = k;
        if (act[2] && rise_k >= 0 && gap < 0) gap = k - rise_k;
      end
      prev_vs = vs[2];
    end
    check("full hsync low clocks 2 lines", 64'(full_hs), 64'd192);
    check("full active clocks 2 lines", 64'(full_act), 64'd1280);
    check("full frame_start count", 64'(full_fs), 64'd1);
    check("small hsync low 2 frames", 64'(s_hs), 64'd170);
    check("small vsync low 2 frames", 64'(s_vs), 64'd128);
    check("small active 2 frames", 64'(s_act), 64'd400);
    check("small frame_start 2 frames", 64'(s_fs), 64'd2);
    check("small vsync rise to active", 64'(gap), 64'd96);

    // Mid-line reset (full raster at h=300, v=2): outputs idle in the same cycle.
    #1 rst_n = 1'b0;
    #1 check_idle("midline reset");
    step();
    rst_n = 1'b1;
    for (int s = 1; s <= 5; s++) begin
      step();
      check($sformatf("fs full after reset s=%0d", s), 64'(fs[0]), 64'(s == 2));
      check($sformatf("fs lat1 after reset s=%0d", s), 64'(fs[1]), 64'(s == 1));
      check($sformatf("fs lat4 after reset s=%0d", s), 64'(fs[3]), 64'(s == 4));
    end

    // Enable drops at random points, the first one 10 clocks long.
    for (int d = 0; d < 3; d++) begin
      n = $urandom_range(100, 700);
      repeat (n) step();
      enable = 1'b0;
      len = (d == 0) ? 10 : $urandom_range(1, 15);
      step();
      check_idle($sformatf("enable drop %0d", d));
      repeat (len - 1) step();
      enable = 1'b1;
      for (int s = 1; s <= 5; s++) begin
        step();
        check($sformatf("fs full re-enable %0d s=%0d", d, s), 64'(fs[0]), 64'(s == 2));
        check($sformatf("fs lat4 re-enable %0d s=%0d", d, s), 64'(fs[3]), 64'(s == 4));
      end
    end

    // Asynchronous resets at random points within a cycle.
    for (int r = 0; r < 2; r++) begin
      n = $urandom_range(50, 400);
      repeat (n) step();
      #($urandom_range(0, 1)) rst_n = 1'b0;
      #1 check_idle($sformatf("async reset %0d", r));
      repeat (2) step();
      rst_n = 1'b1;
    end
    repeat (600) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
